// File: rtl/instr_encoder_fifo.sv
// Packs decoded instruction fields into the 32-bit stage-1 format and queues them in a small FIFO.
// Optional macro INSTR_ENC_R0_GUARD_EN suppresses register-file writes to r0 and flags them on err_r0.
module instr_encoder_fifo #(
    parameter int         DEPTH    = 4,
    parameter logic [1:0] TOP_BITS = 2'b01
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_ReadSelect1,
    input  logic [4:0]               in_ReadSelect2,
    input  logic [15:0]              in_Imm,
    input  logic                     in_DataSrc,
    input  logic [2:0]               in_ALUOp,
    input  logic [4:0]               in_WriteSelect,
    input  logic                     in_WriteEnable,
    output logic [31:0]              InstrOut,
    output logic                     WriteEnable,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_r0
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [31:0]      r_mem [DEPTH];
    logic [DEPTH-1:0] r_we_mem;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [15:0]      w_low16;
    logic [31:0]      w_word;
    logic             w_we_store;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // in_ready is purely occupancy-based: a pop in the same cycle never frees a slot for a push
    assign w_push  = in_valid && !w_full && !flush;
    assign w_pop   = !w_empty && out_ready && !flush;

    assign w_low16 = in_DataSrc ? in_Imm : {in_ReadSelect2, 11'b0};
    assign w_word  = {TOP_BITS, in_DataSrc, in_ALUOp, in_WriteSelect, in_ReadSelect1, w_low16};

`ifdef INSTR_ENC_R0_GUARD_EN
    logic w_r0_hit;
    logic r_err_r0;

    assign w_r0_hit   = in_WriteEnable && (in_WriteSelect == 5'd0);
    assign w_we_store = in_WriteEnable && !w_r0_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_r0 <= 1'b0;
        end else begin
            r_err_r0 <= w_push && w_r0_hit;
        end
    end

    assign err_r0 = r_err_r0;
`else
    assign w_we_store = in_WriteEnable;
    assign err_r0     = 1'b0;
`endif

    // Storage needs no reset; validity is tracked by the pointers and count alone
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr]    <= w_word;
            r_we_mem[r_wr_ptr] <= w_we_store;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign in_ready    = !w_full;
    assign out_valid   = !w_empty;
    assign count       = r_count;
    assign InstrOut    = w_empty ? 32'd0 : r_mem[r_rd_ptr];
    assign WriteEnable = w_empty ? 1'b0  : r_we_mem[r_rd_ptr];

endmodule
